// File: rtl/freq_meter.sv
// Period and high-time meter for a slow asynchronous input, measured rising edge
// to rising edge in clk cycles, with saturating counters and a no-signal flag.
module freq_meter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             sig_in,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             valid,
   output logic             ovf,
   output logic             no_sig
);

   typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state, state_nxt;
   logic             s1, s2, s3;
   logic             rise;
   logic             cap;
   logic [CNT_W-1:0] cnt, hacc;
   logic [CNT_W-1:0] cnt_nxt, hacc_nxt;

   assign rise = s2 & ~s3;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // en low forces IDLE from any state, even on a rise in MEAS
   always_comb begin
      state_nxt = state;
      if (!en) begin
         state_nxt = IDLE;
      end else begin
         unique case (state)
            IDLE:    state_nxt = ARM;
            ARM:     if (rise) state_nxt = MEAS;
            MEAS:    state_nxt = MEAS;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      cap      = 1'b0;
      cnt_nxt  = '0;
      hacc_nxt = '0;
      no_sig   = (state == MEAS) && (cnt == CNT_MAX);
      if (en) begin
         unique case (state)
            ARM: begin
               if (rise) begin
                  cnt_nxt  = CNT_W'(1);
                  hacc_nxt = CNT_W'(1);
               end
            end
            MEAS: begin
               if (rise) begin
                  cap      = 1'b1;
                  cnt_nxt  = CNT_W'(1);
                  hacc_nxt = CNT_W'(1);
               end else begin
                  cnt_nxt  = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
                  hacc_nxt = (s2 && hacc != CNT_MAX) ? hacc + CNT_W'(1) : hacc;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1        <= 1'b0;
         s2        <= 1'b0;
         s3        <= 1'b0;
         cnt       <= '0;
         hacc      <= '0;
         period    <= '0;
         high_time <= '0;
         ovf       <= 1'b0;
         valid     <= 1'b0;
      end else begin
         s1    <= sig_in;
         s2    <= s1;
         s3    <= s2;
         cnt   <= cnt_nxt;
         hacc  <= hacc_nxt;
         valid <= cap;
         if (cap) begin
            period    <= cnt;
            high_time <= hacc;
            ovf       <= (cnt == CNT_MAX);
         end
      end
   end

endmodule

// File: tb/tb_freq_meter.sv
// Randomized bench for freq_meter: a 16-bit and a 4-bit instance share stimulus
// and are checked every cycle against a timestamp-based reference model.
module tb_freq_meter;

   logic        clk = 1'b0;
   logic        rst_n, en, sig_in;
   logic [15:0] period16, high16;
   logic [3:0]  period4, high4;
   logic        valid16, ovf16, nosig16;
   logic        valid4, ovf4, nosig4;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   freq_meter #(.CNT_W(16)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in),
      .period(period16), .high_time(high16), .valid(valid16),
      .ovf(ovf16), .no_sig(nosig16)
   );

   freq_meter #(.CNT_W(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in),
      .period(period4), .high_time(high4), .valid(valid4),
      .ovf(ovf4), .no_sig(nosig4)
   );

   always #5 clk = ~clk;

   // Reference model: edge timestamps and an unbounded high count,
   // saturated only when results are reported.
   longint cyc = 0;
   logic   m_s1 = 1'b0, m_s2 = 1'b0, m_s3 = 1'b0;
   logic   m_active = 1'b0, m_meas = 1'b0;
   longint t0 = 0, highs = 0;
   longint maxv   [2] = '{65535, 15};
   longint e_per  [2] = '{0, 0};
   longint e_ht   [2] = '{0, 0};
   longint e_ovf  [2] = '{0, 0};
   longint e_nsig [2] = '{0, 0};
   logic   e_valid = 1'b0;

   function automatic longint lmin(longint a, longint b);
      return (a < b) ? a : b;
   endfunction

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
      end
   endtask

   task automatic model_edge();
      logic rise;
      rise = m_s2 & ~m_s3;
      e_valid = 1'b0;
      if (!rst_n) begin
         m_s1 = 0; m_s2 = 0; m_s3 = 0;
         m_active = 0; m_meas = 0;
         for (int d = 0; d < 2; d++) begin
            e_per[d] = 0; e_ht[d] = 0; e_ovf[d] = 0;
         end
      end else begin
         if (!en) begin
            m_active = 0;
            m_meas   = 0;
         end else if (!m_active) begin
            m_active = 1;
         end else if (!m_meas) begin
            if (rise) begin
               m_meas = 1; t0 = cyc; highs = 1;
            end
         end else if (rise) begin
            for (int d = 0; d < 2; d++) begin
               e_per[d] = lmin(cyc - t0, maxv[d]);
               e_ht[d]  = lmin(highs, maxv[d]);
               e_ovf[d] = ((cyc - t0) >= maxv[d]) ? 1 : 0;
            end
            e_valid = 1'b1;
            t0 = cyc; highs = 1;
         end else begin
            highs += m_s2;
         end
         m_s3 = m_s2; m_s2 = m_s1; m_s1 = sig_in;
      end
      for (int d = 0; d < 2; d++)
         e_nsig[d] = (m_meas && (cyc - t0 + 1) >= maxv[d]) ? 1 : 0;
   endtask

   task automatic step(input logic s, input logic e, input logic r);
      sig_in = s; en = e; rst_n = r;
      @(posedge clk);
      model_edge();
      #1;
      check("valid16",  valid16,  e_valid);
      check("period16", period16, e_per[0]);
      check("high16",   high16,   e_ht[0]);
      check("ovf16",    ovf16,    e_ovf[0]);
      check("nosig16",  nosig16,  e_nsig[0]);
      check("valid4",   valid4,   e_valid);
      check("period4",  period4,  e_per[1]);
      check("high4",    high4,    e_ht[1]);
      check("ovf4",     ovf4,     e_ovf[1]);
      check("nosig4",   nosig4,   e_nsig[1]);
      cyc++;
   endtask

   // n periods of a P-cycle wave high for H; optional en drop around the
   // rise of period en_drop, optional one-cycle reset mid-period rst_at.
   task automatic wave(input int p, input int h, input int n,
                       input int en_drop, input int rst_at);
      logic e, r;
      for (int k = 0; k < n; k++) begin
         for (int ph = 0; ph < p; ph++) begin
            e = 1'b1; r = 1'b1;
            if (k == en_drop && ph >= 1 && ph <= 3) e = 1'b0;
            if (k == rst_at && ph == p / 2) r = 1'b0;
            step(ph < h, e, r);
         end
      end
   endtask

   initial begin
      int p, h, n, ed, ra;
      sig_in = 1'b0; en = 1'b0; rst_n = 1'b0;
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);

      wave(5, 1, 8, -1, -1);
      wave(10, 5, 5, -1, -1);
      wave(20, 10, 4, -1, -1);
      step(1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'b1);
      wave(12, 4, 5, -1, 2);
      wave(10, 5, 7, 3, -1);

      for (int seg = 0; seg < 40; seg++) begin
         p  = int'($urandom_range(3, 40));
         h  = int'($urandom_range(1, p - 1));
         n  = int'($urandom_range(2, 6));
         ed = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
         ra = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, n - 1)) : -1;
         wave(p, h, n, ed, ra);
      end

      for (int i = 0; i < 300; i++)
         step(1'(($urandom_range(0, 3) == 0) ? 1 : 0),
              1'(($urandom_range(0, 49) != 0) ? 1 : 0),
              1'(($urandom_range(0, 99) != 0) ? 1 : 0));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 Parameter CNT_W, default 16, is the width of the period and high-time counters and results.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low, sampled on the rising edge of clk.
REQ-004 en  input  1  measurement enable; level-sensitive.
REQ-005 sig_in  input  1  asynchronous slow square/pulse wave to be measured.
REQ-006 period  output  CNT_W  last measured rising-to-rising period, in clk cycles.
REQ-007 high_time  output  CNT_W  clk cycles the synchronized signal was high within that period.
REQ-008 valid  output  1  one-cycle pulse when period/high_time update.
REQ-009 ovf  output  1  set with valid when the reported period saturated.
REQ-010 no_sig  output  1  level, high while the running counter is saturated (no edge seen).

Function
REQ-011 sig_in passes through a 2-flop synchronizer (s1, s2) plus history flop s3; rise = s2 & ~s3, combinational.
REQ-012 FSM states: IDLE, ARM, MEAS.
REQ-013 IDLE: leaves to ARM when en=1; counters held at 0.
REQ-014 ARM: waits for rise; on rise go to MEAS, cnt<=1, hacc<=1; no valid.
REQ-015 MEAS, no rise: cnt<=cnt+1 and hacc<=hacc+s2, each saturating at 2^CNT_W-1.
REQ-016 MEAS, rise: period<=cnt, high_time<=hacc, ovf<=(cnt==max), valid<=1 next cycle only, then cnt<=1, hacc<=1; stay in MEAS.
REQ-017 Resulting value: rises N cycles apart give period=N; high_time equals the number of window cycles with s2=1.
REQ-018 valid is registered: asserted exactly one cycle, the cycle after the rise cycle; period/high_time/ovf change only in that same cycle.
REQ-019 period, high_time, ovf hold their values between valid pulses.
REQ-020 no_sig=1 while in MEAS with cnt==max; clears on the cycle after the next rise.
REQ-021 hacc never exceeds cnt; both saturate independently without wrap.
REQ-022 en=0 in any state: next state IDLE, cnt/hacc cleared, no valid; results and ovf hold; synchronizer keeps running.
REQ-023 en=0 on the same cycle as a rise in MEAS: en wins, no valid issued.
REQ-024 Re-enable: enters ARM; the first rise after re-enable never produces valid.
REQ-025 Latency from sig_in rising before clk edge k to rise true: cycle after edge k+1 (2-flop sync).

Reset
REQ-026 rst_n=0 at a clk edge: state<=IDLE; s1,s2,s3,cnt,hacc<=0; period,high_time<=0; valid,ovf,no_sig<=0.
REQ-027 Reset has priority over en and rise; asserted mid-measurement it discards the partial count with no valid.
REQ-028 After rst_n returns to 1, behaviour restarts from IDLE; first valid requires two rises.

Verification
REQ-029 en=1, sig_in period 5 high 1 (divide-by-5 tick) -> first valid after second rise; period=5, high_time=1, ovf=0; valid every 5 cycles thereafter.
REQ-030 sig_in period 10, high 5 -> period=10, high_time=5 on every valid; valid exactly one cycle wide.
REQ-031 CNT_W=4, sig_in period 20 high 10 -> period=15, high_time=10, ovf=1; no_sig=1 from cnt reaching 15 until cycle after rise.
REQ-032 sig_in constant 0 after one rise -> no valid ever; cnt saturates; no_sig=1 held; period holds previous value.
REQ-033 rst_n=0 for one cycle mid-period -> all outputs 0 next cycle; next two rises needed before valid with correct period.
REQ-034 en dropped for 3 cycles coinciding with a rise -> no valid for that rise; previous period held; after re-enable first rise silent, second gives correct period.
